// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU tag encodings, stack op codes and tag classifier
package fpu_pkg;

    localparam logic [1:0] TAG_VALID   = 2'b00;
    localparam logic [1:0] TAG_ZERO    = 2'b01;
    localparam logic [1:0] TAG_SPECIAL = 2'b10;
    localparam logic [1:0] TAG_EMPTY   = 2'b11;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_PUSH      = 4'd1,
        OP_POP       = 4'd2,
        OP_WRITE     = 4'd3,
        OP_WRITE_POP = 4'd4,
        OP_XCH       = 4'd5,
        OP_FREE      = 4'd6,
        OP_INCSTP    = 4'd7,
        OP_DECSTP    = 4'd8,
        OP_INIT      = 4'd9
    } op_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XCH2 = 2'd1,
        ST_CLR  = 2'd2
    } stk_state_e;

    // Field reductions are done by the caller so the function is width independent.
    function automatic logic [1:0] fpu_tag_classify(
        input logic exp_zero,
        input logic exp_ones,
        input logic mant_zero,
        input logic int_bit
    );
        if (exp_zero && mant_zero) begin
            return TAG_ZERO;
        end else if (exp_ones || exp_zero || !int_bit) begin
            return TAG_SPECIAL;
        end else begin
            return TAG_VALID;
        end
    endfunction

endpackage

// File: rtl/fpu_reg_file.sv
// rtl/fpu_reg_file.sv - FPU data/tag register file, one write port, tag-free port, async reads
module fpu_reg_file
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 80,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_idx,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [1:0]         wr_tag,
    input  logic               free_en,
    input  logic [PTR_W-1:0]   free_idx,
    input  logic [PTR_W-1:0]   rd_idx_a,
    input  logic [PTR_W-1:0]   rd_idx_b,
    input  logic [PTR_W-1:0]   rd_idx_c,
    input  logic [PTR_W-1:0]   rd_idx_d,
    output logic [WIDTH-1:0]   rd_data_a,
    output logic [WIDTH-1:0]   rd_data_b,
    output logic [WIDTH-1:0]   rd_data_c,
    output logic [WIDTH-1:0]   rd_data_d,
    output logic [1:0]         rd_tag_a,
    output logic [1:0]         rd_tag_b,
    output logic [2*DEPTH-1:0] tag_word
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [1:0]       tag_q  [DEPTH];
    logic [1:0]       tag_d  [DEPTH];

    // The free port wins over the data port so a same-register WRITE_POP ends empty.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        if (wr_en) begin
            data_d[wr_idx] = wr_data;
            tag_d[wr_idx]  = wr_tag;
        end
        if (free_en) begin
            tag_d[free_idx] = TAG_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= TAG_EMPTY;
            end
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    assign rd_data_a = data_q[rd_idx_a];
    assign rd_data_b = data_q[rd_idx_b];
    assign rd_data_c = data_q[rd_idx_c];
    assign rd_data_d = data_q[rd_idx_d];
    assign rd_tag_a  = tag_q[rd_idx_a];
    assign rd_tag_b  = tag_q[rd_idx_b];

    always_comb begin
        tag_word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            tag_word[2*k +: 2] = tag_q[k];
        end
    end

endmodule

// File: rtl/fpu_reg_stack.sv
// rtl/fpu_reg_stack.sv - 8087-style FPU register stack with fault detection, FXCH and FINIT scrub
module fpu_reg_stack
    import fpu_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int EXP_W  = 15,
    parameter int MANT_W = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int WIDTH = 1 + EXP_W + MANT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [3:0]         op_code,
    input  logic [PTR_W-1:0]   op_idx,
    input  logic [WIDTH-1:0]   op_data,
    output logic               op_done,
    output logic               fault,
    output logic               fault_c1,
    input  logic [PTR_W-1:0]   rd_idx_a,
    input  logic [PTR_W-1:0]   rd_idx_b,
    output logic [WIDTH-1:0]   rd_data_a,
    output logic [WIDTH-1:0]   rd_data_b,
    output logic [1:0]         rd_tag_a,
    output logic [1:0]         rd_tag_b,
    output logic [PTR_W-1:0]   top,
    output logic [2*DEPTH-1:0] tag_word
);

    stk_state_e       state_q, state_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [PTR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0] xch_pidx_q, xch_pidx_d;
    logic [WIDTH-1:0] tmp_data_q, tmp_data_d;
    logic [1:0]       tmp_tag_q, tmp_tag_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             c1_q, c1_d;

    logic             wr_en, free_en;
    logic [PTR_W-1:0] wr_idx, free_idx;
    logic [WIDTH-1:0] wr_data;
    logic [1:0]       wr_tag;

    logic [PTR_W-1:0] st0_p, sti_p, push_p;
    logic [WIDTH-1:0] st0_data, sti_data;
    logic [1:0]       tag_st0, tag_sti, tag_push, in_tag;

    assign st0_p  = top_q;
    assign sti_p  = top_q + op_idx;
    assign push_p = top_q - PTR_W'(1);

    assign tag_st0  = tag_word[{st0_p, 1'b0} +: 2];
    assign tag_sti  = tag_word[{sti_p, 1'b0} +: 2];
    assign tag_push = tag_word[{push_p, 1'b0} +: 2];

    assign in_tag = fpu_tag_classify(op_data[MANT_W +: EXP_W] == '0,
                                     &op_data[MANT_W +: EXP_W],
                                     op_data[MANT_W-1:0] == '0,
                                     op_data[MANT_W-1]);

    fpu_reg_file #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PTR_W (PTR_W)
    ) u_reg_file (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_tag    (wr_tag),
        .free_en   (free_en),
        .free_idx  (free_idx),
        .rd_idx_a  (top_q + rd_idx_a),
        .rd_idx_b  (top_q + rd_idx_b),
        .rd_idx_c  (st0_p),
        .rd_idx_d  (sti_p),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_data_c (st0_data),
        .rd_data_d (sti_data),
        .rd_tag_a  (rd_tag_a),
        .rd_tag_b  (rd_tag_b),
        .tag_word  (tag_word)
    );

    always_comb begin
        state_d    = state_q;
        top_d      = top_q;
        clr_cnt_d  = clr_cnt_q;
        xch_pidx_d = xch_pidx_q;
        tmp_data_d = tmp_data_q;
        tmp_tag_d  = tmp_tag_q;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        c1_d       = c1_q;
        wr_en      = 1'b0;
        wr_idx     = sti_p;
        wr_data    = op_data;
        wr_tag     = in_tag;
        free_en    = 1'b0;
        free_idx   = st0_p;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    done_d = 1'b1;
                    case (op_code)
                        OP_PUSH: begin
                            if (tag_push == TAG_EMPTY) begin
                                top_d  = push_p;
                                wr_en  = 1'b1;
                                wr_idx = push_p;
                            end else begin
                                fault_d = 1'b1;
                                c1_d    = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (tag_st0 != TAG_EMPTY) begin
                                free_en = 1'b1;
                                top_d   = top_q + PTR_W'(1);
                            end else begin
                                fault_d = 1'b1;
                                c1_d    = 1'b0;
                            end
                        end
                        OP_WRITE: begin
                            wr_en = 1'b1;
                        end
                        OP_WRITE_POP: begin
                            if (tag_st0 != TAG_EMPTY) begin
                                wr_en   = (op_idx != '0);
                                free_en = 1'b1;
                                top_d   = top_q + PTR_W'(1);
                            end else begin
                                fault_d = 1'b1;
                                c1_d    = 1'b0;
                            end
                        end
                        OP_XCH: begin
                            if (tag_st0 == TAG_EMPTY || tag_sti == TAG_EMPTY) begin
                                fault_d = 1'b1;
                                c1_d    = 1'b0;
                            end else if (op_idx != '0) begin
                                // First half: ST0 takes ST(i); old ST0 parks in temp.
                                done_d     = 1'b0;
                                state_d    = ST_XCH2;
                                wr_en      = 1'b1;
                                wr_idx     = st0_p;
                                wr_data    = sti_data;
                                wr_tag     = tag_sti;
                                tmp_data_d = st0_data;
                                tmp_tag_d  = tag_st0;
                                xch_pidx_d = sti_p;
                            end
                        end
                        OP_FREE: begin
                            free_en  = 1'b1;
                            free_idx = sti_p;
                        end
                        OP_INCSTP: top_d = top_q + PTR_W'(1);
                        OP_DECSTP: top_d = top_q - PTR_W'(1);
                        OP_INIT: begin
                            done_d    = 1'b0;
                            state_d   = ST_CLR;
                            clr_cnt_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_XCH2: begin
                wr_en   = 1'b1;
                wr_idx  = xch_pidx_q;
                wr_data = tmp_data_q;
                wr_tag  = tmp_tag_q;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            ST_CLR: begin
                wr_en     = 1'b1;
                wr_idx    = clr_cnt_q;
                wr_data   = '0;
                wr_tag    = TAG_EMPTY;
                top_d     = '0;
                clr_cnt_d = clr_cnt_q + PTR_W'(1);
                if (clr_cnt_q == PTR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            top_q      <= '0;
            clr_cnt_q  <= '0;
            xch_pidx_q <= '0;
            tmp_data_q <= '0;
            tmp_tag_q  <= TAG_EMPTY;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            c1_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            top_q      <= top_d;
            clr_cnt_q  <= clr_cnt_d;
            xch_pidx_q <= xch_pidx_d;
            tmp_data_q <= tmp_data_d;
            tmp_tag_q  <= tmp_tag_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            c1_q       <= c1_d;
        end
    end

    assign op_ready = (state_q == ST_IDLE);
    assign op_done  = done_q;
    assign fault    = fault_q;
    assign fault_c1 = c1_q;
    assign top      = top_q;

endmodule

// File: tb/tb_fpu_reg_stack.sv
// tb/tb_fpu_reg_stack.sv - self-checking bench for fpu_reg_stack (DEPTH=8 model, DEPTH=4 directed)
module tb_fpu_reg_stack;

    localparam int D = 8;
    localparam int W = 80;

    localparam logic [W-1:0] ONE  = 80'h3FFF8000000000000000;
    localparam logic [W-1:0] M25  = 80'hC000A000000000000000;
    localparam logic [W-1:0] INF  = 80'h7FFF8000000000000000;
    localparam logic [W-1:0] DEN  = 80'h00004000000000000000;
    localparam logic [W-1:0] UNN  = 80'h3FFF4000000000000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          op_valid, op_ready, op_done, fault, fault_c1;
    logic [3:0]    op_code;
    logic [2:0]    op_idx, rd_idx_a, rd_idx_b, top;
    logic [W-1:0]  op_data, rd_data_a, rd_data_b;
    logic [1:0]    rd_tag_a, rd_tag_b;
    logic [15:0]   tag_word;

    logic          op4_valid, op4_ready, op4_done, op4_fault, op4_c1;
    logic [3:0]    op4_code;
    logic [1:0]    op4_idx, rd4_idx_a, rd4_idx_b, top4, rd4_tag_a, rd4_tag_b;
    logic [39:0]   op4_data, rd4_data_a, rd4_data_b;
    logic [7:0]    tag_word4;

    fpu_reg_stack u_dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_idx(op_idx), .op_data(op_data), .op_done(op_done),
        .fault(fault), .fault_c1(fault_c1), .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
        .top(top), .tag_word(tag_word)
    );

    fpu_reg_stack #(.DEPTH(4), .EXP_W(15), .MANT_W(24)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .op_valid(op4_valid), .op_ready(op4_ready),
        .op_code(op4_code), .op_idx(op4_idx), .op_data(op4_data), .op_done(op4_done),
        .fault(op4_fault), .fault_c1(op4_c1), .rd_idx_a(rd4_idx_a), .rd_idx_b(rd4_idx_b),
        .rd_data_a(rd4_data_a), .rd_data_b(rd4_data_b), .rd_tag_a(rd4_tag_a), .rd_tag_b(rd4_tag_b),
        .top(top4), .tag_word(tag_word4)
    );

    int total = 0;
    int bad = 0;

    logic [W-1:0] m_data [D];
    logic [1:0]   m_tag  [D];
    int           m_top;
    bit           m_busy, m_done, m_fault, m_c1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] cls(input logic [W-1:0] v);
        logic [14:0] e;
        logic [63:0] m;
        e = v[78:64];
        m = v[63:0];
        if (e == 15'd0 && m == 64'd0) return 2'b01;
        if (e == 15'h7FFF || e == 15'd0 || !m[63]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int st(input int i);
        return (m_top + i) % D;
    endfunction

    function automatic logic [15:0] m_tw();
        logic [15:0] tw;
        for (int k = 0; k < D; k++) tw[2*k +: 2] = m_tag[k];
        return tw;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) begin
            m_data[k] = '0;
            m_tag[k]  = 2'b11;
        end
        m_top = 0; m_busy = 0; m_done = 0; m_fault = 0; m_c1 = 0;
    endtask

    task automatic underflow();
        m_fault = 1; m_c1 = 0;
    endtask

    task automatic m_apply(input logic [3:0] code, input int idx, input logic [W-1:0] data);
        int p, a, b;
        logic [W-1:0] t;
        logic [1:0] tt;
        m_fault = 0;
        case (code)
            4'd1: begin
                p = (m_top + D - 1) % D;
                if (m_tag[p] == 2'b11) begin
                    m_top = p; m_data[p] = data; m_tag[p] = cls(data);
                end else begin
                    m_fault = 1; m_c1 = 1;
                end
            end
            4'd2: if (m_tag[m_top] != 2'b11) begin
                      m_tag[m_top] = 2'b11; m_top = (m_top + 1) % D;
                  end else underflow();
            4'd3: begin p = st(idx); m_data[p] = data; m_tag[p] = cls(data); end
            4'd4: if (m_tag[m_top] == 2'b11) underflow();
                  else begin
                      if (idx != 0) begin p = st(idx); m_data[p] = data; m_tag[p] = cls(data); end
                      m_tag[m_top] = 2'b11; m_top = (m_top + 1) % D;
                  end
            4'd5: begin
                a = st(0); b = st(idx);
                if (m_tag[a] == 2'b11 || m_tag[b] == 2'b11) underflow();
                else begin
                    t = m_data[a]; tt = m_tag[a];
                    m_data[a] = m_data[b]; m_tag[a] = m_tag[b];
                    m_data[b] = t; m_tag[b] = tt;
                end
            end
            4'd6: m_tag[st(idx)] = 2'b11;
            4'd7: m_top = (m_top + 1) % D;
            4'd8: m_top = (m_top + D - 1) % D;
            4'd9: begin
                for (int k = 0; k < D; k++) begin m_data[k] = '0; m_tag[k] = 2'b11; end
                m_top = 0;
            end
            default: ;
        endcase
    endtask

    function automatic int busy_edges(input logic [3:0] code, input int idx);
        if (code == 4'd9) return D;
        if (code == 4'd5 && idx != 0 && m_tag[st(0)] != 2'b11 && m_tag[st(idx)] != 2'b11) return 1;
        return 0;
    endfunction

    task automatic issue(input logic [3:0] code, input int idx, input logic [W-1:0] data);
        int be;
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = code; op_idx = 3'(idx); op_data = data;
        @(posedge clk);
        be = busy_edges(code, idx);
        if (be == 0) begin
            m_apply(code, idx, data); m_done = 1;
        end else begin
            m_busy = 1;
        end
        #1; op_valid = 1'b0; op_code = 4'd0;
        if (be > 0) begin
            repeat (be) @(posedge clk);
            m_apply(code, idx, data); m_busy = 0; m_done = 1;
        end
        @(posedge clk);
        m_done = 0; m_fault = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset_n = 1'b0; model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic lit_st(input string n, input int i, input logic [W-1:0] d, input logic [1:0] t);
        @(negedge clk); #2;
        rd_idx_a = 3'(i); #1;
        chk({n, "_data"}, rd_data_a, d);
        chk({n, "_tag"}, {78'd0, rd_tag_a}, {78'd0, t});
    endtask

    task automatic lit_top(input string n, input logic [2:0] t, input logic [15:0] tw);
        @(negedge clk); #2;
        chk({n, "_top"}, {77'd0, top}, {77'd0, t});
        chk({n, "_tagword"}, {64'd0, tag_word}, {64'd0, tw});
    endtask

    task automatic issue4(input logic [3:0] code, input logic [1:0] idx, input logic [39:0] data,
                          output logic d, output logic f);
        @(posedge clk); #1;
        op4_valid = 1'b1; op4_code = code; op4_idx = idx; op4_data = data;
        @(posedge clk); #1;
        op4_valid = 1'b0; op4_code = 4'd0;
        @(negedge clk);
        d = op4_done; f = op4_fault;
    endtask

    // Per-cycle comparison of every observable output against the model
    initial begin
        rd_idx_b = 3'd0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("op_ready", {79'd0, op_ready}, {79'd0, !m_busy});
                chk("op_done", {79'd0, op_done}, {79'd0, m_done});
                chk("fault", {79'd0, fault}, {79'd0, m_fault});
                chk("fault_c1", {79'd0, fault_c1}, {79'd0, m_c1});
                if (!m_busy) begin
                    chk("top", {77'd0, top}, W'(m_top));
                    chk("tag_word", {64'd0, tag_word}, {64'd0, m_tw()});
                    chk("rd_data_a", rd_data_a, m_data[st(int'(rd_idx_a))]);
                    chk("rd_tag_a", {78'd0, rd_tag_a}, {78'd0, m_tag[st(int'(rd_idx_a))]});
                    chk("rd_data_b", rd_data_b, m_data[st(int'(rd_idx_b))]);
                    chk("rd_tag_b", {78'd0, rd_tag_b}, {78'd0, m_tag[st(int'(rd_idx_b))]});
                end
            end
            rd_idx_b = rd_idx_b + 3'd1;
        end
    end

    initial begin
        logic d4, f4;
        reset_n = 1'b0;
        op_valid = 1'b0; op_code = '0; op_idx = '0; op_data = '0; rd_idx_a = '0;
        op4_valid = 1'b0; op4_code = '0; op4_idx = '0; op4_data = '0; rd4_idx_a = '0; rd4_idx_b = 2'd1;
        model_reset();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        lit_top("reset", 3'd0, 16'hFFFF);

        issue(4'd1, 0, ONE);
        lit_top("push1", 3'd7, 16'h3FFF);
        lit_st("push1_st0", 0, ONE, 2'b00);

        issue(4'd1, 0, '0);
        issue(4'd1, 0, INF);
        lit_st("zero_st1", 1, '0, 2'b01);
        lit_st("inf_st0", 0, INF, 2'b10);
        issue(4'd2, 0, '0);
        issue(4'd2, 0, '0);
        lit_top("pop2", 3'd7, 16'h3FFF);
        lit_st("pop2_st0", 0, ONE, 2'b00);

        do_reset();
        for (int k = 0; k < D; k++) issue(4'd1, 0, {1'b0, 15'h3FFF + 15'(k), 64'h8000000000000000 | 64'(k)});
        issue(4'd1, 0, ONE);
        lit_top("overflow", 3'd0, 16'h0000);
        chk("overflow_c1", {79'd0, fault_c1}, 80'd1);
        for (int k = 0; k < D; k++) issue(4'd2, 0, '0);
        issue(4'd2, 0, '0);
        lit_top("underflow", 3'd0, 16'hFFFF);
        chk("underflow_c1", {79'd0, fault_c1}, 80'd0);

        do_reset();
        issue(4'd1, 0, M25);
        issue(4'd1, 0, ONE);
        issue(4'd5, 1, '0);
        lit_st("xch_st0", 0, M25, 2'b00);
        lit_st("xch_st1", 1, ONE, 2'b00);
        issue(4'd5, 3, '0);
        issue(4'd5, 0, '0);
        issue(4'd3, 2, DEN);
        lit_st("write_den", 2, DEN, 2'b10);
        issue(4'd6, 2, '0);
        issue(4'd4, 1, UNN);
        issue(4'd12, 0, ONE);
        lit_st("wpop_st0", 0, UNN, 2'b10);

        do_reset();
        for (int k = 0; k < D; k++) issue(4'd1, 0, ONE);
        issue(4'd9, 0, '0);
        lit_top("init", 3'd0, 16'hFFFF);
        for (int k = 0; k < D; k++) issue(4'd1, 0, M25);
        @(posedge clk); #1;
        op_valid = 1'b1; op_code = 4'd9;
        @(posedge clk);
        m_busy = 1;
        #1; op_valid = 1'b0; op_code = 4'd0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0; model_reset();
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (D + 2) @(posedge clk);
        lit_top("init_rst", 3'd0, 16'hFFFF);

        do_reset();
        issue(4'd8, 0, '0);
        lit_top("decstp_wrap", 3'd7, 16'hFFFF);
        issue(4'd7, 0, '0);
        lit_top("incstp_wrap", 3'd0, 16'hFFFF);
        issue(4'd1, 0, ONE);
        issue(4'd4, 0, M25);
        lit_top("wpop0", 3'd0, 16'hFFFF);

        do_reset();
        lit_top("d4_pre", 3'd0, 16'hFFFF);
        chk("d4_reset_top", {78'd0, top4}, 80'd0);
        chk("d4_reset_tw", {72'd0, tag_word4}, 80'hFF);
        issue4(4'd8, 2'd0, '0, d4, f4);
        chk("d4_dec_done", {79'd0, d4}, 80'd1);
        chk("d4_dec_top", {78'd0, top4}, 80'd3);
        issue4(4'd7, 2'd0, '0, d4, f4);
        chk("d4_inc_top", {78'd0, top4}, 80'd0);
        for (int k = 0; k < 4; k++) issue4(4'd1, 2'd0, 40'h3FFF800000, d4, f4);
        chk("d4_full_tw", {72'd0, tag_word4}, 80'h00);
        issue4(4'd1, 2'd0, 40'h3FFF800000, d4, f4);
        chk("d4_ovf_fault", {79'd0, f4}, 80'd1);
        chk("d4_ovf_c1", {79'd0, op4_c1}, 80'd1);
        chk("d4_ovf_top", {78'd0, top4}, 80'd0);
        issue4(4'd4, 2'd0, 40'h4000800000, d4, f4);
        chk("d4_wpop_fault", {79'd0, f4}, 80'd0);
        chk("d4_wpop_top", {78'd0, top4}, 80'd1);
        chk("d4_wpop_tw", {72'd0, tag_word4}, 80'h03);
        chk("d4_st0_data", {40'd0, rd4_data_a}, 80'h3FFF800000);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
